// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for the EXE stage (RV32M DIV/DIVU/REM/REMU).
// One quotient bit per cycle. Divide-by-zero and signed overflow resolve in a single cycle.
// The result is registered and loaded only on entry to DONE.

module exe_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   input  logic            hold_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [XLEN-1:0] MinSigned = {1'b1, {(XLEN - 1){1'b0}}};

   // State and datapath registers
   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rem_sel_q, rem_sel_d;   // 1: remainder requested, 0: quotient
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;           // dividend bits shift out as quotient bits shift in
   logic [XLEN-1:0] div_q, div_d;
   logic [XLEN-1:0] result_q, result_d;

   // Operand decode, used only when a new operation is accepted
   logic            is_signed;
   logic            is_rem;
   logic            rs1_neg;
   logic            rs2_neg;
   logic [XLEN-1:0] rs1_mag;
   logic [XLEN-1:0] rs2_mag;
   logic            div_by_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_res;

   // Iteration datapath
   logic [XLEN:0]   rem_shift;
   logic            rem_ge;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] final_res;

   // Decode operation type, operand magnitudes and the single-cycle special cases
   always_comb begin
      is_signed   = ~op_i[0];
      is_rem      = op_i[1];
      rs1_neg     = is_signed & rs1_i[XLEN-1];
      rs2_neg     = is_signed & rs2_i[XLEN-1];
      rs1_mag     = rs1_neg ? ('0 - rs1_i) : rs1_i;
      rs2_mag     = rs2_neg ? ('0 - rs2_i) : rs2_i;
      div_by_zero = (rs2_i == '0);
      overflow    = is_signed & (rs1_i == MinSigned) & (rs2_i == '1);
      special     = div_by_zero | overflow;
      if (div_by_zero) begin
         special_res = is_rem ? rs1_i : '1;
      end else begin
         special_res = is_rem ? '0 : rs1_i;
      end
   end

   // One restoring step plus the sign fixup applied after the last step
   always_comb begin
      // Partial remainder is XLEN+1 bits wide so the compare never loses the carried-out bit
      rem_shift = {rem_q, quo_q[XLEN-1]};
      rem_ge    = (rem_shift >= {1'b0, div_q});
      // After a successful compare the difference is below div_q, so it fits in XLEN bits
      rem_step  = rem_ge ? (rem_shift[XLEN-1:0] - div_q) : rem_shift[XLEN-1:0];
      quo_step  = {quo_q[XLEN-2:0], rem_ge};
      quo_fix   = neg_quo_q ? ('0 - quo_step) : quo_step;
      rem_fix   = neg_rem_q ? ('0 - rem_step) : rem_step;
      final_res = rem_sel_q ? rem_fix : quo_fix;
   end

   // Next-state logic; flush overrides everything and leaves result untouched
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_sel_d = rem_sel_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      result_d  = result_q;

      if (flush_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  rem_sel_d = is_rem;
                  neg_quo_d = rs1_neg ^ rs2_neg;
                  neg_rem_d = rs1_neg;
                  rem_d     = '0;
                  quo_d     = rs1_mag;
                  div_d     = rs2_mag;
                  cnt_d     = '0;
                  if (special) begin
                     result_d = special_res;
                     state_d  = StDone;
                  end else begin
                     state_d  = StCalc;
                  end
               end
            end
            StCalc: begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  result_d = final_res;
                  state_d  = StDone;
               end
            end
            StDone: begin
               // start_i here still belongs to the instruction just completed
               if (!hold_i) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_sel_q <= rem_sel_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         result_q  <= result_d;
      end
   end

   // Outputs; stall drops in DONE so the pipeline can advance
   always_comb begin
      stall_o  = ((state_q == StIdle) & start_i & ~flush_i) | (state_q == StCalc);
      done_o   = (state_q == StDone);
      result_o = result_q;
   end

endmodule
